bcd_encoder: RTL and testbench



---
 rtl/bcd_encoder.sv | 59 +++++
 tb/tb_bcd_encoder.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/bcd_encoder.sv
// Registered binary-to-BCD converter.
// Shift-and-add-3 core feeding a single output register stage.
module bcd_encoder #(
  parameter int BIN_W  = 4,
  parameter int DIGITS =
    ((BIN_W * 30103 + 99999) / 100000 < 2) ? 2 :
    ((BIN_W * 30103 + 99999) / 100000)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [BIN_W-1:0]      bin,
  output logic [3:0]            bcd,
  output logic [3:0]            bcd_tens,
  output logic [4*DIGITS-1:0]   bcd_all,
  output logic                  ovf,
  output logic                  valid
);

  localparam int W = 4 * DIGITS + BIN_W;

  logic [W-1:0]          sh;
  logic [4*DIGITS-1:0]   conv;
  logic [BIN_W+3:0]      binx;
  logic                  big;

  // Digits sit above the binary field; bits shift up into them MSB first.
  always_comb begin
    sh = {{(4*DIGITS){1'b0}}, bin};
    for (int i = 0; i < BIN_W; i++) begin
      for (int d = 0; d < DIGITS; d++) begin
        if (sh[BIN_W+4*d +: 4] >= 4'd5)
          sh[BIN_W+4*d +: 4] = sh[BIN_W+4*d +: 4] + 4'd3;
      end
      sh = sh << 1;
    end
    conv = sh[W-1:BIN_W];
  end

  // Widened so the compare against 9 is legal for narrow inputs.
  assign binx = {4'b0000, bin};
  assign big  = (binx > (BIN_W+4)'(9));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bcd_all  <= '0;
      bcd      <= '0;
      bcd_tens <= '0;
      ovf      <= 1'b0;
      valid    <= 1'b0;
    end else begin
      bcd_all  <= conv;
      bcd      <= conv[3:0];
      bcd_tens <= conv[7:4];
      ovf      <= big;
      valid    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bcd_encoder.sv
// Directed bench for bcd_encoder.
// Covers default 4-bit and an 8-bit instance.
module tb_bcd_encoder;

  logic        clk;
  logic        rst_n;
  logic [3:0]  bin;
  logic [3:0]  bcd;
  logic [3:0]  bcd_tens;
  logic [7:0]  bcd_all;
  logic        ovf;
  logic        valid;

  logic [7:0]  bin8;
  logic [3:0]  bcd8;
  logic [3:0]  tens8;
  logic [11:0] all8;
  logic        ovf8;
  logic        valid8;

  int tests;
  int fails;

  bcd_encoder dut (
    .clk(clk), .rst_n(rst_n), .bin(bin),
    .bcd(bcd), .bcd_tens(bcd_tens),
    .bcd_all(bcd_all), .ovf(ovf),
    .valid(valid)
  );

  bcd_encoder #(.BIN_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .bin(bin8),
    .bcd(bcd8), .bcd_tens(tens8),
    .bcd_all(all8), .ovf(ovf8),
    .valid(valid8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bin   = 4'b1111;
    bin8  = 8'd255;
    step();
    step();
    tests++;
    if ({bcd, bcd_tens, ovf, valid} !== 10'd0) begin
      fails++;
      $display("FAIL reset: got bcd=%0d tens=%0d ovf=%b valid=%b, want 0 0 0 0",
               bcd, bcd_tens, ovf, valid);
    end
    tests++;
    if (bcd_all !== 8'h00 || all8 !== 12'h000 || valid8 !== 1'b0) begin
      fails++;
      $display("FAIL reset_all: got %h %h v8=%b, want 00 000 0",
               bcd_all, all8, valid8);
    end
  endtask

  task automatic test_in_range();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bin = 4'(i);
      step();
      tests++;
      if (bcd !== 4'(i) || bcd_tens !== 4'd0 ||
          ovf !== 1'b0 || valid !== 1'b1) begin
        fails++;
        $display("FAIL in_range %0d: got bcd=%0d tens=%0d ovf=%b valid=%b",
                 i, bcd, bcd_tens, ovf, valid);
      end
    end
  endtask

  task automatic test_out_of_range();
    logic [3:0] vin [2]  = '{4'd10, 4'd15};
    logic [3:0] vone [2] = '{4'd0, 4'd5};
    logic [7:0] vall [2] = '{8'h10, 8'h15};
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      bin = vin[i];
      step();
      tests++;
      if (bcd !== vone[i] || bcd_tens !== 4'd1 ||
          ovf !== 1'b1 || bcd_all !== vall[i]) begin
        fails++;
        $display("FAIL out_of_range %0d: got %0d %0d ovf=%b all=%h, want %0d 1 1 %h",
                 vin[i], bcd, bcd_tens, ovf, bcd_all, vone[i], vall[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] vin [3]  = '{4'd3, 4'd12, 4'd7};
    logic [3:0] vone [3] = '{4'd3, 4'd2, 4'd7};
    logic [3:0] vten [3] = '{4'd0, 4'd1, 4'd0};
    @(negedge clk);
    bin = vin[0];
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      if (i < 2) bin = vin[i+1];
      #1;
      tests++;
      if (bcd !== vone[i] || bcd_tens !== vten[i]) begin
        fails++;
        $display("FAIL back_to_back %0d: got (%0d,%0d), want (%0d,%0d)",
                 i, bcd, bcd_tens, vone[i], vten[i]);
      end
    end
  endtask

  task automatic test_midstream_reset();
    @(negedge clk);
    bin   = 4'd13;
    rst_n = 1'b0;
    step();
    tests++;
    if ({bcd, bcd_tens, bcd_all, ovf, valid} !== 18'd0) begin
      fails++;
      $display("FAIL mid_reset: got %0d %0d %h ovf=%b valid=%b, want zeros",
               bcd, bcd_tens, bcd_all, ovf, valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    tests++;
    if (bcd !== 4'd3 || bcd_tens !== 4'd1 ||
        ovf !== 1'b1 || valid !== 1'b1) begin
      fails++;
      $display("FAIL mid_release: got %0d %0d ovf=%b valid=%b, want 3 1 1 1",
               bcd, bcd_tens, ovf, valid);
    end
  endtask

  task automatic test_wide();
    logic [7:0]  vin [4]  = '{8'd255, 8'd99, 8'd100, 8'd9};
    logic [11:0] vexp [4] = '{12'h255, 12'h099, 12'h100, 12'h009};
    logic        vovf [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bin8 = vin[i];
      step();
      tests++;
      if (all8 !== vexp[i] || ovf8 !== vovf[i] ||
          bcd8 !== vexp[i][3:0] || tens8 !== vexp[i][7:4]) begin
        fails++;
        $display("FAIL wide %0d: got all=%h ovf=%b, want %h %b",
                 vin[i], all8, ovf8, vexp[i], vovf[i]);
      end
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    bin   = 4'd0;
    bin8  = 8'd0;
    test_reset();
    test_in_range();
    test_out_of_range();
    test_back_to_back();
    test_midstream_reset();
    test_wide();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
